drop_animator: RTL and testbench
================================

# drop_animator

Drives the falling-token animation for a single Connect-4 move. It consumes the `enable` tick from the rate divider and steps a token from the top row of the chosen column down to its landing row, one row per tick. On each step it emits draw and erase requests for the VGA drawing logic downstream, and signals completion to the game controller.

## Interface
Parameters:
- ROWS, 6, number of board rows; row 0 is the top row.
- COLS, 7, number of board columns.

Ports:
- clk  input  1  system clock.
- clear_b  input  1  reset; asynchronous, active-low.
- tick  input  1  one-cycle step strobe from the rate divider `enable`.
- start  input  1  move request; sampled only in IDLE.
- col  input  3  column of the move; latched on accepted start.
- target_row  input  3  landing row; latched on accepted start.
- busy  output  1  high while an animation is in progress.
- cur_col  output  3  column of the token being animated.
- cur_row  output  3  current token row.
- prev_row  output  3  row to erase; valid when erase=1.
- draw  output  1  one-cycle pulse: draw token at (cur_col, cur_row).
- erase  output  1  one-cycle pulse: erase token at (cur_col, prev_row).
- done  output  1  one-cycle pulse: animation finished.
- reject  output  1  one-cycle pulse: start refused (col ≥ COLS or target_row ≥ ROWS).
- flash  output  1  landing highlight; present only with DROP_LAND_HOLD_EN, otherwise tied 0.

## Operation
- States: IDLE, FALL, LAND. LAND exists only with DROP_LAND_HOLD_EN.
- Reset (clear_b=0, at any time including mid-animation):
  - state goes to IDLE.
  - All outputs go to 0, including cur_row, cur_col, prev_row and flash.
- IDLE, on start=1:
  - If col < COLS and target_row < ROWS: latch col and target_row, set cur_row=0, pulse draw, and go to FALL.
  - Otherwise: pulse reject and stay in IDLE.
- IDLE, without start: tick is ignored.
- FALL, on tick=1:
  - If cur_row ≠ target: set prev_row=cur_row, increment cur_row, and pulse draw and erase together.
  - If cur_row = target: the token has landed. Pulse done and go to IDLE. With the macro, go to LAND instead.
- start while busy=1 is ignored: no reject and no latch.
- tick on the same cycle as an accepted start does not step. The first step uses the next tick.
- target_row=0: the token lands on the first tick after start, with no erase issued.
- cur_row never exceeds target_row. No wrap-around is possible.
- Outputs hold their values between ticks. cur_row/cur_col keep their last values after done until the next accepted start.

## Timing
- All outputs are registered.
- Accepted start at cycle N: busy=1, cur_row=0, draw=1 at N+1.
- Rejected start at cycle N: reject=1 at N+1, busy stays 0.
- Tick at cycle M in FALL: the updated cur_row/prev_row/draw/erase, or done, appear at M+1.
- Landing: done=1 and busy=0 appear in the same cycle.
- Without the macro, ticks from start to done = target_row+1.
- A new start is accepted on the cycle after done falls, i.e. while busy=0.

## Configuration
- DROP_LAND_HOLD_EN defined:
  - The landing tick moves FALL to LAND with flash=1. No done yet.
  - In LAND, each tick toggles flash.
  - The second LAND tick clears flash, pulses done, and returns to IDLE.
  - Total ticks = target_row+3. busy stays 1 throughout LAND.
- Not defined: LAND is absent, flash is constant 0, and done is issued on the landing tick.

## Test plan
- Reset mid-fall: col=3, target_row=4, assert clear_b=0 after 2 ticks -> next edge gives busy=0, cur_row=0, cur_col=0, no done.
- Normal drop: col=2, target_row=5 -> draw at rows 0..5, erase prev_row 0..4, done after the 6th tick, busy low the same cycle.
- target_row=0, col=6 -> draw at row 0, no erase, done on the first tick.
- Invalid request: start with target_row=6, then with col=7 -> reject pulse each time, busy=0, cur_row/cur_col unchanged.
- Simultaneous events: tick coincident with start leaves cur_row=0; start during FALL is ignored (col change does not affect cur_col).
- DROP_LAND_HOLD_EN, target_row=1 -> flash 1 on the 2nd tick, 0 on the 3rd, done on the 4th tick, busy=1 throughout.

Source files
------------

// File: rtl/drop_animator.sv
// Falling-token animator for one Connect-4 move: steps a token down one row per tick.
// Optional landing highlight (LAND state, flash output) enabled by defining DROP_LAND_HOLD_EN.
module drop_animator #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       clk,
    input  logic       clear_b,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] col,
    input  logic [2:0] target_row,
    output logic       busy,
    output logic [2:0] cur_col,
    output logic [2:0] cur_row,
    output logic [2:0] prev_row,
    output logic       draw,
    output logic       erase,
    output logic       done,
    output logic       reject,
    output logic       flash
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FALL = 2'd1;
`ifdef DROP_LAND_HOLD_EN
    localparam logic [1:0] LAND = 2'd2;
    logic       flash_q;
    logic       land_second;
    assign flash = flash_q;
`else
    assign flash = 1'b0;
`endif

    logic [1:0] state;
    logic [2:0] tgt;
    logic       start_ok;

    assign start_ok = (int'(col) < COLS) && (int'(target_row) < ROWS);

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state    <= IDLE;
            tgt      <= 3'd0;
            busy     <= 1'b0;
            cur_col  <= 3'd0;
            cur_row  <= 3'd0;
            prev_row <= 3'd0;
            draw     <= 1'b0;
            erase    <= 1'b0;
            done     <= 1'b0;
            reject   <= 1'b0;
`ifdef DROP_LAND_HOLD_EN
            flash_q     <= 1'b0;
            land_second <= 1'b0;
`endif
        end else begin
            // NOTE: pulses default low every cycle; the case below raises them for exactly one cycle.
            draw   <= 1'b0;
            erase  <= 1'b0;
            done   <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            cur_col <= col;
                            tgt     <= target_row;
                            cur_row <= 3'd0;
                            draw    <= 1'b1;
                            busy    <= 1'b1;
                            state   <= FALL;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                FALL: begin
                    if (tick) begin
                        if (cur_row != tgt) begin
                            prev_row <= cur_row;
                            cur_row  <= cur_row + 3'd1;
                            draw     <= 1'b1;
                            erase    <= 1'b1;
                        end else begin
`ifdef DROP_LAND_HOLD_EN
                            flash_q     <= 1'b1;
                            land_second <= 1'b0;
                            state       <= LAND;
`else
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
`endif
                        end
                    end
                end
`ifdef DROP_LAND_HOLD_EN
                LAND: begin
                    if (tick) begin
                        if (!land_second) begin
                            flash_q     <= ~flash_q;
                            land_second <= 1'b1;
                        end else begin
                            flash_q <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drop_animator.sv
// Self-checking bench for drop_animator: directed table, landing sequences and random
// stimulus scored against a tick-counting reference model.
module tb_drop_animator;

    localparam int ROWS = 6;
    localparam int COLS = 7;
`ifdef DROP_LAND_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear_b = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [2:0] col = 3'd0;
    logic [2:0] target_row = 3'd0;
    logic       busy, draw, erase, done, reject, flash;
    logic [2:0] cur_col, cur_row, prev_row;

    drop_animator #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .clear_b(clear_b), .tick(tick), .start(start),
        .col(col), .target_row(target_row), .busy(busy),
        .cur_col(cur_col), .cur_row(cur_row), .prev_row(prev_row),
        .draw(draw), .erase(erase), .done(done), .reject(reject), .flash(flash)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a move is "k ticks since the accepted start"; every output follows from k.
    bit m_busy;
    int m_k, m_tgt, m_col, m_row, m_prev;
    bit e_draw, e_erase, e_done, e_reject, e_flash;

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_tgt = 0; m_col = 0; m_row = 0; m_prev = 0;
        e_draw = 0; e_erase = 0; e_done = 0; e_reject = 0; e_flash = 0;
    endtask

    task automatic model_step(input logic s, input logic t, input logic [2:0] c, input logic [2:0] r);
        int total;
        e_draw = 0; e_erase = 0; e_done = 0; e_reject = 0;
        if (!m_busy) begin
            if (s) begin
                if (int'(c) < COLS && int'(r) < ROWS) begin
                    m_busy = 1; m_k = 0; m_tgt = int'(r); m_col = int'(c); m_row = 0;
                    e_draw = 1;
                end else begin
                    e_reject = 1;
                end
            end
        end else if (t) begin
            total = m_tgt + 1 + (HOLD ? 2 : 0);
            m_k++;
            if (m_k <= m_tgt) begin
                m_prev = m_k - 1; m_row = m_k; e_draw = 1; e_erase = 1;
            end
            if (m_k == total) begin
                e_done = 1; m_busy = 0;
            end
        end
        e_flash = HOLD && m_busy && (m_k == m_tgt + 1);
    endtask

    task automatic compare_model(input string tag);
        check({tag, " busy"},     32'(busy),     32'(m_busy));
        check({tag, " cur_row"},  32'(cur_row),  32'(m_row));
        check({tag, " cur_col"},  32'(cur_col),  32'(m_col));
        check({tag, " prev_row"}, 32'(prev_row), 32'(m_prev));
        check({tag, " draw"},     32'(draw),     32'(e_draw));
        check({tag, " erase"},    32'(erase),    32'(e_erase));
        check({tag, " done"},     32'(done),     32'(e_done));
        check({tag, " reject"},   32'(reject),   32'(e_reject));
        check({tag, " flash"},    32'(flash),    32'(e_flash));
    endtask

    // Apply one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic step(input logic s, input logic t, input logic [2:0] c, input logic [2:0] r);
        start = s; tick = t; col = c; target_row = r;
        model_step(s, t, c, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; tick = 0;
        clear_b = 1'b0;
        #2;
        model_reset();
        compare_model("async reset");
        @(negedge clk);
        clear_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Full move with tick every cycle; checks every cycle and the tick count to done.
    task automatic drop_count(input logic [2:0] c, input logic [2:0] r, input string tag);
        int n;
        bit seen;
        n = 0; seen = 0;
        step(1'b1, 1'b0, c, r);
        compare_model({tag, " start"});
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 1'b1, 3'd0, 3'd0);
            compare_model({tag, " fall"});
            n++;
            if (done) seen = 1;
        end
        check({tag, " ticks to done"}, 32'(n), 32'(int'(r) + 1 + (HOLD ? 2 : 0)));
        step(1'b0, 1'b0, 3'd0, 3'd0);
        compare_model({tag, " after done"});
    endtask

    typedef struct {
        logic       s, t;
        logic [2:0] c, r;
        logic       busy;
        logic [2:0] row, colq, prev;
        logic       draw, erase, done, reject;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 3'd7, 3'd2, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 3'd1, 3'd6, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd1, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 3'd5, 3'd0, 1'b1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd2, 3'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0};

        model_reset();
        #12;
        compare_model("in reset");
        do_reset();
        compare_model("idle after reset");

        // Directed table: idle tick, two rejects, start with coincident tick, ignored start.
        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].t, tbl[i].c, tbl[i].r);
            check($sformatf("vec%0d busy", i),     32'(busy),     32'(tbl[i].busy));
            check($sformatf("vec%0d cur_row", i),  32'(cur_row),  32'(tbl[i].row));
            check($sformatf("vec%0d cur_col", i),  32'(cur_col),  32'(tbl[i].colq));
            check($sformatf("vec%0d prev_row", i), 32'(prev_row), 32'(tbl[i].prev));
            check($sformatf("vec%0d draw", i),     32'(draw),     32'(tbl[i].draw));
            check($sformatf("vec%0d erase", i),    32'(erase),    32'(tbl[i].erase));
            check($sformatf("vec%0d done", i),     32'(done),     32'(tbl[i].done));
            check($sformatf("vec%0d reject", i),   32'(reject),   32'(tbl[i].reject));
        end
        // Finish the table's move (landing tick, plus LAND ticks when enabled).
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 3'd0, 3'd0);
            compare_model("table tail");
        end

        drop_count(3'd2, 3'd5, "normal drop");
        drop_count(3'd6, 3'd0, "target 0");
        drop_count(3'd0, 3'd1, "target 1");

        // Rejects leave the last cur_row/cur_col untouched.
        step(1'b1, 1'b0, 3'd3, 3'd6);
        compare_model("reject row6");
        step(1'b1, 1'b0, 3'd7, 3'd0);
        compare_model("reject col7");

        // Reset mid-fall after two ticks.
        step(1'b1, 1'b0, 3'd3, 3'd4);
        step(1'b0, 1'b1, 3'd0, 3'd0);
        step(1'b0, 1'b1, 3'd0, 3'd0);
        compare_model("pre-reset fall");
        clear_b = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_model("reset mid-fall");
        @(negedge clk);
        clear_b = 1'b1;

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                compare_model("random");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
